// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX operand forwarding selects and load-use stall control for a 5-stage pipe.
module fwd_hazard_unit #(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             stall
);
  typedef enum logic {RUN, HOLD} state_t;
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             uses_rs;
    logic             uses_rt;
    logic [REG_W-1:0] rd;
    logic             wr;
    logic             mrd;
  } ex_t;
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             wr;
  } wbk_t;
  ex_t    ex_q, ex_d;
  wbk_t   mem_q, mem_d, wb_q, wb_d;
  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic hazard;
  // MEM-stage producer wins over WB; register 0 is hardwired and never forwarded
  function automatic logic [1:0] sel(input logic use_r, input logic [REG_W-1:0] r);
    logic live;
    live = ex_q.valid & use_r & (r != '0);
    return (live & mem_q.valid & mem_q.wr & (mem_q.rd == r)) ? 2'b01 :
           (live & wb_q.valid & wb_q.wr & (wb_q.rd == r))    ? 2'b10 : 2'b00;
  endfunction
  always_comb begin
    fwd_a  = sel(ex_q.uses_rs, ex_q.rs);
    fwd_b  = sel(ex_q.uses_rt, ex_q.rt);
    hazard = id_valid & ex_q.valid & ex_q.mrd & ex_q.wr & (ex_q.rd != '0) &
             ((id_uses_rs & (id_rs == ex_q.rd)) | (id_uses_rt & (id_rt == ex_q.rd)));
    stall   = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == RUN) begin
      stall = hazard & ~flush;
      if (stall && LOAD_LAT > 1) begin
        state_d = HOLD;
        cnt_d   = 2'(LOAD_LAT - 1);
      end
    end else begin
      stall = ~flush;
      cnt_d = cnt_q - 2'd1;
      state_d = (cnt_q == 2'd1 || flush) ? RUN : HOLD;
    end
    ex_d  = (!stall && !flush && id_valid) ?
            '{1'b1, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd, id_reg_write, id_mem_read} : '0;
    mem_d = '{ex_q.valid, ex_q.rd, ex_q.wr};
    wb_d  = mem_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed forwarding/stall scenarios on LOAD_LAT=1 and LOAD_LAT=3 instances.
module tb_fwd_hazard_unit;
  typedef struct packed {
    logic v;
    logic [4:0] rs, rt;
    logic urs, urt;
    logic [4:0] rd;
    logic rw, mr, fl;
  } in_t;
  typedef struct {
    int w;
    int id;
    logic [1:0] a, b;
    logic s;
  } exp_t;
  logic clk = 0, rst = 1;
  in_t i1 = '0, i3 = '0;
  logic [1:0] a1, b1, a3, b3;
  logic s1, s3;
  exp_t q[$];
  int errors = 0, checks = 0, n = 0;
  always #5 clk = ~clk;
  fwd_hazard_unit #(.REG_W(5), .LOAD_LAT(1)) u1 (
    .clk(clk), .rst(rst), .id_valid(i1.v), .id_rs(i1.rs), .id_rt(i1.rt),
    .id_uses_rs(i1.urs), .id_uses_rt(i1.urt), .id_rd(i1.rd), .id_reg_write(i1.rw),
    .id_mem_read(i1.mr), .flush(i1.fl), .fwd_a(a1), .fwd_b(b1), .stall(s1));
  fwd_hazard_unit #(.REG_W(5), .LOAD_LAT(3)) u3 (
    .clk(clk), .rst(rst), .id_valid(i3.v), .id_rs(i3.rs), .id_rt(i3.rt),
    .id_uses_rs(i3.urs), .id_uses_rt(i3.urt), .id_rd(i3.rd), .id_reg_write(i3.rw),
    .id_mem_read(i3.mr), .flush(i3.fl), .fwd_a(a3), .fwd_b(b3), .stall(s3));
  function automatic in_t alu(input logic [4:0] rd, rs, rt, input logic fl = 0);
    return '{1'b1, rs, rt, 1'b1, 1'b1, rd, 1'b1, 1'b0, fl};
  endfunction
  function automatic in_t ld(input logic [4:0] rd, rs);
    return '{1'b1, rs, 5'd0, 1'b1, 1'b0, rd, 1'b1, 1'b1, 1'b0};
  endfunction
  task automatic step(input int w, input in_t x, input logic [1:0] ea = 0, eb = 0,
                      input logic es = 0, input logic r = 0);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    i1 = (w == 1) ? x : '0;
    i3 = (w == 3) ? x : '0;
    n++;
    e.w = w; e.id = n; e.a = ea; e.b = eb; e.s = es;
    q.push_back(e);
  endtask
  task automatic idle(input int w, input int k);
    for (int i = 0; i < k; i++) step(w, '0);
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [1:0] oa, ob;
      logic os;
      e  = q.pop_front();
      oa = (e.w == 1) ? a1 : a3;
      ob = (e.w == 1) ? b1 : b3;
      os = (e.w == 1) ? s1 : s3;
      checks++;
      assert (oa === e.a) else begin
        errors++;
        $error("FAIL fwd_a u%0d step %0d: got %b want %b", e.w, e.id, oa, e.a);
      end
      checks++;
      assert (ob === e.b) else begin
        errors++;
        $error("FAIL fwd_b u%0d step %0d: got %b want %b", e.w, e.id, ob, e.b);
      end
      checks++;
      assert (os === e.s) else begin
        errors++;
        $error("FAIL stall u%0d step %0d: got %b want %b", e.w, e.id, os, e.s);
      end
    end
  end
  initial begin
    // reset state
    step(1, '0, 0, 0, 0, 1);
    step(3, '0, 0, 0, 0, 1);
    step(1, '0);
    // back-to-back ALU: add r3 ; sub r5,r3,r4
    step(1, alu(3, 1, 2));
    step(1, alu(5, 3, 4));
    step(1, '0, 2'b01, 2'b00, 0);
    // writer, unrelated op, reader on rt -> WB forward
    step(1, alu(3, 1, 2));
    step(1, alu(7, 1, 2));
    step(1, alu(8, 4, 3));
    step(1, '0, 2'b00, 2'b10, 0);
    // two writers of r3 -> MEM beats WB on both operands
    step(1, alu(3, 1, 2));
    step(1, alu(3, 1, 2));
    step(1, alu(9, 3, 3));
    step(1, '0, 2'b01, 2'b01, 0);
    idle(1, 3);
    // load-use, LOAD_LAT=1
    step(1, ld(2, 1));
    step(1, alu(6, 2, 1), 0, 0, 1);
    step(1, alu(6, 2, 1), 0, 0, 0);
    step(1, '0, 2'b10, 2'b00, 0);
    idle(1, 3);
    // register 0 never forwards or stalls
    step(1, alu(0, 1, 2));
    step(1, ld(0, 1));
    step(1, alu(4, 0, 0));
    step(1, '0);
    step(1, '0);
    idle(1, 3);
    // load-use with flush the same cycle: no stall, add squashed
    step(1, ld(2, 1));
    step(1, alu(6, 2, 1, 1));
    step(1, '0);
    idle(1, 3);
    // load-use, LOAD_LAT=3
    step(3, ld(2, 1));
    step(3, alu(6, 2, 1), 0, 0, 1);
    step(3, alu(6, 2, 1), 0, 0, 1);
    step(3, alu(6, 2, 1), 0, 0, 1);
    step(3, alu(6, 2, 1), 0, 0, 0);
    step(3, '0);
    idle(3, 3);
    // LOAD_LAT=3, flush in the 2nd HOLD cycle
    step(3, ld(2, 1));
    step(3, alu(6, 2, 1), 0, 0, 1);
    step(3, alu(6, 2, 1), 0, 0, 1);
    step(3, alu(6, 2, 1, 1), 0, 0, 0);
    step(3, '0);
    idle(3, 3);
    // LOAD_LAT=3, flush in the 1st HOLD cycle returns to RUN
    step(3, ld(2, 1));
    step(3, alu(6, 2, 1), 0, 0, 1);
    step(3, alu(6, 2, 1, 1), 0, 0, 0);
    step(3, '0);
    step(3, '0);
    idle(3, 3);
    // LOAD_LAT=3, hazard and flush together stay in RUN
    step(3, ld(2, 1));
    step(3, alu(6, 2, 1, 1));
    step(3, '0);
    step(3, '0);
    idle(3, 3);
    // reset mid-HOLD with live shadow stages
    step(3, alu(3, 1, 2));
    step(3, ld(2, 1));
    step(3, alu(6, 2, 3), 0, 0, 1);
    step(3, alu(6, 2, 3), 0, 0, 1, 1);
    step(3, alu(6, 2, 3), 0, 0, 0, 0);
    step(3, '0, 2'b00, 2'b00, 0);
    step(3, '0);
    @(posedge clk);
    #1;
    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
